// File: rtl/instr_cache_assoc_pkg.sv
// Shared definitions for the instruction cache: FSM encoding and width helpers.
package icache_pkg;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_MISS = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int offBits(input int lineWidth, input int wordWidth);
    return clog2(lineWidth / wordWidth);
  endfunction

  function automatic int idxBits(input int numSets);
    return clog2(numSets);
  endfunction

  function automatic int tagBits(input int addrWidth, input int lineWidth,
                                 input int wordWidth, input int numSets);
    return addrWidth - offBits(lineWidth, wordWidth) - idxBits(numSets);
  endfunction

endpackage

// File: rtl/instr_cache_assoc_if.sv
// Fetch-side and arbiter-side signal bundle of the instruction cache.
interface instr_cache_assoc_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_BITS   = 10,
  parameter int WORD_WIDTH = 16,
  parameter int LINE_WIDTH = 256
);
  // petFromProc qualifies a lookup every cycle and isHit is its same-cycle answer;
  // petitionToArb stays high with addrToArb stable until memServiceReady, and the
  // line on dataReadFromMem is consumed on that same clock edge.
  logic [ADDR_WIDTH-1:0] virt_address;
  logic [TAG_BITS-1:0]   phys_address;
  logic                  petFromProc;
  logic                  flush;
  logic                  memServiceReady;
  logic [LINE_WIDTH-1:0] dataReadFromMem;
  logic [WORD_WIDTH-1:0] instructionBits;
  logic                  isHit;
  logic [ADDR_WIDTH-1:0] addrToArb;
  logic                  petitionToArb;
  logic                  busy;
  logic                  stateDbg;

  modport master (
    output virt_address, phys_address, petFromProc, flush, memServiceReady, dataReadFromMem,
    input  instructionBits, isHit, addrToArb, petitionToArb, busy, stateDbg
  );

  modport slave (
    input  virt_address, phys_address, petFromProc, flush, memServiceReady, dataReadFromMem,
    output instructionBits, isHit, addrToArb, petitionToArb, busy, stateDbg
  );
endinterface

// File: rtl/instr_cache_assoc_way.sv
// One way of the cache: per-set line, tag and valid storage with a single write port
// and an asynchronous read port.
module instr_cache_way
  import icache_pkg::*;
#(
  parameter int NUM_SETS   = 4,
  parameter int TAG_BITS   = 10,
  parameter int LINE_WIDTH = 256,
  localparam int IDX_BITS  = idxBits(NUM_SETS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  we,
  input  logic [IDX_BITS-1:0]   wrSet,
  input  logic [TAG_BITS-1:0]   wrTag,
  input  logic [LINE_WIDTH-1:0] wrLine,
  input  logic [IDX_BITS-1:0]   rdSet,
  output logic [LINE_WIDTH-1:0] rdLine,
  output logic [TAG_BITS-1:0]   rdTag,
  output logic                  rdValid
);

  logic [LINE_WIDTH-1:0] lineMem [NUM_SETS];
  logic [TAG_BITS-1:0]   tagMem  [NUM_SETS];
  logic [NUM_SETS-1:0]   validQ;

  // A flush on the fill edge still lets the line and tag land, but leaves it invalid.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      validQ <= '0;
    end else if (we) begin
      validQ[wrSet] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      lineMem[wrSet] <= wrLine;
      tagMem[wrSet]  <= wrTag;
    end
  end

  assign rdLine  = lineMem[rdSet];
  assign rdTag   = tagMem[rdSet];
  assign rdValid = validQ[rdSet];

endmodule

// File: rtl/instr_cache_assoc.sv
// Set-associative (1 or 2 way) VIPT instruction cache with LRU replacement and refill FSM.
// Optional hit/miss counters are built when INSTR_CACHE_STATS_EN is defined.
module instr_cache_assoc
  import icache_pkg::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input  logic clk,
  input  logic reset,
  instr_cache_assoc_if.slave bus
`ifdef INSTR_CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OFF_BITS = offBits(LINE_WIDTH, WORD_WIDTH);
  localparam int IDX_BITS = idxBits(NUM_SETS);
  localparam int TAG_BITS = tagBits(ADDR_WIDTH, LINE_WIDTH, WORD_WIDTH, NUM_SETS);
  localparam int WORDS    = LINE_WIDTH / WORD_WIDTH;

  logic [0:0]            stateQ;
  logic [TAG_BITS-1:0]   tagQ;
  logic [IDX_BITS-1:0]   idxQ;
  logic [NUM_SETS-1:0]   lruQ;

  logic [IDX_BITS-1:0]   idx;
  logic [OFF_BITS-1:0]   off;
  logic [IDX_BITS-1:0]   rdSet;
  logic                  fillEn;
  logic                  missStart;
  logic                  anyHit;
  logic                  hitWay;
  logic                  victim;
  logic [LINE_WIDTH-1:0] hitLine;
  logic [WORD_WIDTH-1:0] hitWord;
  logic                  unusedVaTag;

  logic [LINE_WIDTH-1:0] wayLine  [NUM_WAYS];
  logic [TAG_BITS-1:0]   wayTag   [NUM_WAYS];
  logic [NUM_WAYS-1:0]   wayValid;

  assign idx         = bus.virt_address[OFF_BITS +: IDX_BITS];
  assign off         = bus.virt_address[OFF_BITS-1:0];
  assign unusedVaTag = ^bus.virt_address[ADDR_WIDTH-1:OFF_BITS+IDX_BITS];

  // During a miss the ways are read at the latched set so victim choice sees current valids.
  assign rdSet  = (stateQ == STATE_IDLE) ? idx : idxQ;
  assign fillEn = (stateQ == STATE_MISS) && bus.memServiceReady && !reset;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    instr_cache_way #(
      .NUM_SETS  (NUM_SETS),
      .TAG_BITS  (TAG_BITS),
      .LINE_WIDTH(LINE_WIDTH)
    ) u_way (
      .clk    (clk),
      .reset  (reset),
      .flush  (bus.flush),
      .we     (fillEn && (victim == 1'(w))),
      .wrSet  (idxQ),
      .wrTag  (tagQ),
      .wrLine (bus.dataReadFromMem),
      .rdSet  (rdSet),
      .rdLine (wayLine[w]),
      .rdTag  (wayTag[w]),
      .rdValid(wayValid[w])
    );
  end

  // Scan from the top way down so the lowest matching way wins a multi-hit.
  always_comb begin
    anyHit  = 1'b0;
    hitWay  = 1'b0;
    hitLine = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (wayValid[w] && (wayTag[w] == bus.phys_address)) begin
        anyHit  = 1'b1;
        hitWay  = 1'(w);
        hitLine = wayLine[w];
      end
    end
  end

  always_comb begin
    hitWord = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (off == OFF_BITS'(i)) begin
        hitWord = hitLine[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  if (NUM_WAYS == 1) begin : g_victim_dm
    assign victim = 1'b0;
  end else begin : g_victim_assoc
    assign victim = !wayValid[0] ? 1'b0 :
                    !wayValid[1] ? 1'b1 : lruQ[idxQ];
  end

  assign bus.isHit           = (stateQ == STATE_IDLE) && bus.petFromProc && !bus.flush && anyHit;
  assign bus.instructionBits = bus.isHit ? hitWord : '0;
  assign missStart           = (stateQ == STATE_IDLE) && bus.petFromProc && !anyHit && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= STATE_IDLE;
      tagQ   <= '0;
      idxQ   <= '0;
    end else begin
      case (stateQ)
        STATE_IDLE: begin
          if (missStart) begin
            stateQ <= STATE_MISS;
            tagQ   <= bus.phys_address;
            idxQ   <= idx;
          end
        end
        default: begin
          if (bus.memServiceReady) begin
            stateQ <= STATE_IDLE;
          end
        end
      endcase
    end
  end

  // lruQ[set] names the way to evict next when both ways of that set are valid.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      lruQ <= '0;
    end else if (fillEn) begin
      lruQ[idxQ] <= ~victim;
    end else if (bus.isHit && (NUM_WAYS == 2)) begin
      lruQ[idx] <= ~hitWay;
    end
  end

  assign bus.petitionToArb = (stateQ == STATE_MISS);
  assign bus.busy          = (stateQ != STATE_IDLE);
  assign bus.addrToArb     = {tagQ, idxQ, OFF_BITS'(0)};
  assign bus.stateDbg      = stateQ;

`ifdef INSTR_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (bus.isHit && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (missStart && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Scoreboard bench for instr_cache_assoc against a recency-list reference model.
// Counter checks are included when INSTR_CACHE_STATS_EN is defined.
module tb_instr_cache_assoc;

  localparam int LW = 256;
  localparam int WW = 16;
  localparam int AW = 16;
  localparam int NS = 4;
  localparam int NW = 2;
  localparam int TB = 10;

  logic clk;
  logic reset;

  instr_cache_assoc_if #(.ADDR_WIDTH(AW), .TAG_BITS(TB), .WORD_WIDTH(WW), .LINE_WIDTH(LW)) bus ();

`ifdef INSTR_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  instr_cache_assoc #(
    .LINE_WIDTH(LW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_SETS(NS), .NUM_WAYS(NW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef INSTR_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  tid;
    logic        expHit;
    logic [15:0] expWord;
    logic        expPet;
    logic        expBusy;
    logic [15:0] expAddr;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  rec_t monRec;

  task automatic check(input string name, input logic [7:0] tid,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tid=%0d actual=%0h expected=%0h t=%0t", name, tid, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      monRec = exp_q.pop_front();
      check("isHit",           monRec.tid, 32'(bus.isHit),           32'(monRec.expHit));
      check("instructionBits", monRec.tid, 32'(bus.instructionBits), 32'(monRec.expWord));
      check("petitionToArb",   monRec.tid, 32'(bus.petitionToArb),   32'(monRec.expPet));
      check("busy",            monRec.tid, 32'(bus.busy),            32'(monRec.expBusy));
      check("addrToArb",       monRec.tid, 32'(bus.addrToArb),       32'(monRec.expAddr));
    end
  end

  // ---------------- reference model ----------------
  // Each set keeps the resident tags ordered most-recently-used first.
  logic [TB-1:0] mruTags [NS][$];
  logic [LW-1:0] lineStore [logic [11:0]];
  logic [15:0]   lastAddr;
  int unsigned   modelHits;
  int unsigned   modelMisses;

  function automatic int find_pos(input int s, input logic [TB-1:0] t);
    for (int i = 0; i < mruTags[s].size(); i++) begin
      if (mruTags[s][i] == t) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) mruTags[s].delete();
  endtask

  task automatic model_reset();
    model_clear();
    lastAddr    = 16'h0;
    modelHits   = 0;
    modelMisses = 0;
  endtask

  function automatic rec_t mk(input logic [7:0] tid, input logic hit, input logic [15:0] word,
                              input logic pet, input logic bsy, input logic [15:0] addr);
    rec_t r;
    r.tid = tid; r.expHit = hit; r.expWord = word;
    r.expPet = pet; r.expBusy = bsy; r.expAddr = addr;
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cycle(input rec_t r);
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [7:0] tid);
    bus.petFromProc = 1'b0;
    drive_cycle(mk(tid, 1'b0, 16'h0, 1'b0, 1'b0, lastAddr));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.petFromProc = 1'b0; bus.flush = 1'b0; bus.memServiceReady = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_flush(input logic [7:0] tid, input logic [15:0] va, input logic [TB-1:0] pa);
    bus.virt_address = va; bus.phys_address = pa;
    bus.petFromProc = 1'b1; bus.flush = 1'b1;
    drive_cycle(mk(tid, 1'b0, 16'h0, 1'b0, 1'b0, lastAddr));
    bus.flush = 1'b0; bus.petFromProc = 1'b0;
    model_clear();
  endtask

  task automatic do_access(input logic [7:0] tid, input logic [15:0] va, input logic [TB-1:0] pa,
                           input int waitCycles, input bit flushAtFill, input bit resetInMiss,
                           input logic [LW-1:0] fillLine);
    int s;
    int pos;
    logic [TB-1:0] t;
    logic [LW-1:0] l;
    s = int'(va[5:4]);
    bus.virt_address = va; bus.phys_address = pa;
    bus.petFromProc = 1'b1; bus.flush = 1'b0; bus.memServiceReady = 1'b0;
    pos = find_pos(s, pa);
    if (pos >= 0) begin
      l = lineStore[{pa, va[5:4]}];
      drive_cycle(mk(tid, 1'b1, l[int'(va[3:0])*WW +: WW], 1'b0, 1'b0, lastAddr));
      t = mruTags[s][pos];
      mruTags[s].delete(pos);
      mruTags[s].push_front(t);
      modelHits++;
      bus.petFromProc = 1'b0;
      return;
    end
    drive_cycle(mk(tid, 1'b0, 16'h0, 1'b0, 1'b0, lastAddr));
    modelMisses++;
    lastAddr = {pa, va[5:4], 4'h0};
    for (int i = 0; i < waitCycles; i++) begin
      bus.virt_address = 16'($urandom_range(0, 16'hFFFF));
      bus.phys_address = 10'($urandom_range(0, 3));
      bus.petFromProc  = 1'($urandom_range(0, 1));
      drive_cycle(mk(tid, 1'b0, 16'h0, 1'b1, 1'b1, lastAddr));
    end
    if (resetInMiss) begin
      reset = 1'b1;
      drive_cycle(mk(tid, 1'b0, 16'h0, 1'b1, 1'b1, lastAddr));
      reset = 1'b0;
      bus.petFromProc = 1'b0;
      model_reset();
      drive_cycle(mk(tid, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0));
      return;
    end
    bus.memServiceReady = 1'b1;
    bus.dataReadFromMem = fillLine;
    bus.flush = flushAtFill;
    drive_cycle(mk(tid, 1'b0, 16'h0, 1'b1, 1'b1, lastAddr));
    bus.memServiceReady = 1'b0; bus.flush = 1'b0; bus.petFromProc = 1'b0;
    if (flushAtFill) begin
      model_clear();
    end else begin
      if (mruTags[s].size() == NW) void'(mruTags[s].pop_back());
      mruTags[s].push_front(pa);
      lineStore[{pa, va[5:4]}] = fillLine;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [LW-1:0] line;

  initial begin
    reset = 1'b1;
    bus.virt_address = '0; bus.phys_address = '0; bus.petFromProc = 1'b0;
    bus.flush = 1'b0; bus.memServiceReady = 1'b0; bus.dataReadFromMem = '0;
    apply_reset();
    idle_cycle(8'd0);

    // cold miss then hit on the refilled word
    line = rand_line();
    line[5*WW +: WW] = 16'hBEEF;
    do_access(8'd1, 16'h0015, 10'h000, 0, 1'b0, 1'b0, line);
    do_access(8'd1, 16'h0015, 10'h000, 0, 1'b0, 1'b0, rand_line());
    check("word5_beef", 8'd1, 32'(lineStore[{10'h000, 2'd1}][5*WW +: WW]), 32'h0000BEEF);

    // LRU eviction in set 1
    do_access(8'd2, 16'h0013, 10'h001, 1, 1'b0, 1'b0, rand_line());
    do_access(8'd2, 16'h0014, 10'h002, 1, 1'b0, 1'b0, rand_line());
    do_access(8'd2, 16'h0013, 10'h001, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd2, 16'h0019, 10'h003, 2, 1'b0, 1'b0, rand_line());
    do_access(8'd2, 16'h001A, 10'h001, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd2, 16'h0012, 10'h002, 0, 1'b0, 1'b0, rand_line());

    // long stall with the address wandering
    do_access(8'd3, 16'h0027, 10'h005, 5, 1'b0, 1'b0, rand_line());
    do_access(8'd3, 16'h0027, 10'h005, 0, 1'b0, 1'b0, rand_line());

    // flush in idle, then flush coinciding with the fill
    do_access(8'd4, 16'h0031, 10'h006, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd4, 16'h0002, 10'h006, 1, 1'b0, 1'b0, rand_line());
    do_flush(8'd4, 16'h0031, 10'h006);
    do_access(8'd4, 16'h0031, 10'h006, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd4, 16'h0002, 10'h006, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd4, 16'h0025, 10'h009, 1, 1'b1, 1'b0, rand_line());
    do_access(8'd4, 16'h0025, 10'h009, 0, 1'b0, 1'b0, rand_line());

    // reset during a miss
    do_access(8'd5, 16'h0031, 10'h007, 2, 1'b0, 1'b1, rand_line());
    do_access(8'd5, 16'h0031, 10'h007, 0, 1'b0, 1'b0, rand_line());

    // counters: 2 misses, 3 hits, then flush
    apply_reset();
    do_access(8'd6, 16'h0010, 10'h011, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd6, 16'h0020, 10'h012, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd6, 16'h0011, 10'h011, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd6, 16'h0022, 10'h012, 0, 1'b0, 1'b0, rand_line());
    do_access(8'd6, 16'h0013, 10'h011, 0, 1'b0, 1'b0, rand_line());
`ifdef INSTR_CACHE_STATS_EN
    check("hit_count", 8'd6, hit_count, 32'd3);
    check("miss_count", 8'd6, miss_count, 32'd2);
`endif
    do_flush(8'd6, 16'h0010, 10'h011);
`ifdef INSTR_CACHE_STATS_EN
    check("hit_count_flush", 8'd6, hit_count, 32'd3);
    check("miss_count_flush", 8'd6, miss_count, 32'd2);
`endif

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [15:0] va;
      sel = $urandom_range(0, 49);
      va  = 16'($urandom_range(0, 16'hFFFF));
      if (sel == 0) begin
        do_flush(8'd7, va, 10'($urandom_range(0, 3)));
      end else if (sel < 3) begin
        idle_cycle(8'd7);
      end else begin
        do_access(8'd7, va, 10'($urandom_range(0, 3)), $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0), (sel == 3), rand_line());
      end
    end
    idle_cycle(8'd8);
    idle_cycle(8'd8);
`ifdef INSTR_CACHE_STATS_EN
    check("hit_count_final", 8'd8, hit_count, 32'(modelHits));
    check("miss_count_final", 8'd8, miss_count, 32'(modelMisses));
`endif
    check("exp_q_drained", 8'd8, 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_cache_assoc.md
Name: instr_cache_assoc

Overview:
Parametrised, set-associative (1 or 2 way) instruction cache for the FETCH stage.
- Virtually indexed, physically tagged, with a registered refill FSM toward the memory arbiter.
- Adds LRU replacement, a flush/invalidate input, and line-granular refill addressing.
- Sits between the fetch PC/TLB path and the arbiter shared with the data cache.

Parameters:
LINE_WIDTH, 256, bits per cache line (multiple of WORD_WIDTH, power-of-2 ratio)
WORD_WIDTH, 16, instruction word width
ADDR_WIDTH, 16, word-address width
NUM_SETS, 4, sets (power of 2, >=2)
NUM_WAYS, 2, associativity; legal values 1 or 2
Derived: OFF_BITS=clog2(LINE_WIDTH/WORD_WIDTH), IDX_BITS=clog2(NUM_SETS), TAG_BITS=ADDR_WIDTH-OFF_BITS-IDX_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
virt_address  in  ADDR_WIDTH  fetch address; only index/offset bits are used
phys_address  in  TAG_BITS  translated tag from TLB, same cycle as virt_address
petFromProc  in  1  fetch request valid
flush  in  1  one-cycle pulse; invalidate all lines
memServiceReady  in  1  arbiter: dataReadFromMem valid this cycle
dataReadFromMem  in  LINE_WIDTH  refill line
instructionBits  out  WORD_WIDTH  selected word; 0 when isHit=0
isHit  out  1  lookup hit this cycle
addrToArb  out  ADDR_WIDTH  {latched tag, latched index, OFF_BITS'0}
petitionToArb  out  1  refill request to arbiter
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): all valid bits 0, LRU bits 0, state IDLE, latched tag/index 0.
  - Outputs after reset: isHit=0, petitionToArb=0, busy=0, addrToArb=0, instructionBits=0.
- Lookup is combinational in IDLE.
  - hit_w = valid[w][idx] && tag[w][idx]==phys_address.
  - isHit = (state==IDLE) && petFromProc && any hit_w.
  - instructionBits = word[offset] of the hit way.
  - If more than one way hits, that is an error; the lower way wins.
- FSM states:
  - IDLE: on petFromProc && !isHit && !flush, latch phys_address and index, then go to MISS.
    - On a hit, update LRU[idx] to point at the non-hit way (NUM_WAYS=2 only).
  - MISS: petitionToArb=1, busy=1, isHit=0; addrToArb is held stable.
    - When memServiceReady=1: write dataReadFromMem plus the latched tag into the victim way, set valid, set LRU away from the victim, go to IDLE.
- Victim selection: the lowest invalid way in the set; otherwise the LRU way; way 0 when NUM_WAYS=1.
- Miss penalty: at least 2 cycles (miss cycle plus the ready cycle). The same address hits on the cycle after the fill.
- Changes to virt_address or petFromProc during MISS are ignored. The refill always completes, even if the request is dropped.
- flush:
  - Clears all valid and LRU bits in 1 cycle.
  - In IDLE, it suppresses isHit that cycle.
  - In MISS, the request continues. If the flush coincides with the fill cycle, the data and tag are written but valid stays 0 (flush wins).
- Reset during MISS: petitionToArb drops on the next edge; no line is written.
- Writes occur only on a clk edge with state==MISS && memServiceReady.

Optional Feature:
Macro INSTR_CACHE_STATS_EN.
- When defined: adds 32-bit output ports hit_count and miss_count.
  - hit_count increments on each isHit cycle.
  - miss_count increments on each IDLE-to-MISS transition.
  - Both saturate at all-ones and clear on reset only; flush does not clear them.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package icache_pkg holds the clog2 function, state encoding (IDLE=1'b0, MISS=1'b1), and derived-width localparam helpers.
- Sub-module instr_cache_way, instantiated NUM_WAYS times, contains:
  - per-set data, tag and valid registers
  - a write port (we, set, tag, line)
  - combinational read (set -> line, tag, valid)
  - a flush clear
- FSM, LRU bits, victim select and word mux stay in the top level.

Test Plan:
1. After reset, petFromProc=1, va=0x0015, pa tag=0x000 -> isHit=0, next cycle petitionToArb=1, addrToArb=0x0010. Ready with line word5=0xBEEF -> the following cycle isHit=1, instructionBits=0xBEEF.
2. Fill set 1 with tags 0x001 then 0x002, hit tag 0x001, then miss tag 0x003 -> tag 0x002 (LRU) is evicted. A later lookup with tag 0x001 hits; tag 0x002 misses.
3. Hold memServiceReady=0 for 5 cycles in MISS while va changes -> addrToArb is constant, petitionToArb=1 throughout, isHit=0, busy=1.
4. flush in IDLE after 2 fills -> all following lookups miss. Flush on the same cycle as memServiceReady -> state returns to IDLE, and the line misses on re-access.
5. reset asserted mid-MISS -> next cycle petitionToArb=0, busy=0, no hit for the pending address.
6. With INSTR_CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; after flush the counts are unchanged.
